// File: rtl/read_data_router.sv
// AXI R-channel router for the 2-master / 6-slave interconnect. Each slave burst is
// steered to the master named by the upper RID bits, and that tag is stripped on the way.
module read_data_router #(
   parameter int ID_BITS   = 4,
   parameter int IDS_BITS  = 8,
   parameter int DATA_BITS = 32,
   parameter bit RR_EN     = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDS_BITS-1:0]  RID_S0,
   input  logic [IDS_BITS-1:0]  RID_S1,
   input  logic [IDS_BITS-1:0]  RID_S2,
   input  logic [IDS_BITS-1:0]  RID_S3,
   input  logic [IDS_BITS-1:0]  RID_S4,
   input  logic [IDS_BITS-1:0]  RID_S5,
   input  logic [DATA_BITS-1:0] RDATA_S0,
   input  logic [DATA_BITS-1:0] RDATA_S1,
   input  logic [DATA_BITS-1:0] RDATA_S2,
   input  logic [DATA_BITS-1:0] RDATA_S3,
   input  logic [DATA_BITS-1:0] RDATA_S4,
   input  logic [DATA_BITS-1:0] RDATA_S5,
   input  logic [1:0]           RRESP_S0,
   input  logic [1:0]           RRESP_S1,
   input  logic [1:0]           RRESP_S2,
   input  logic [1:0]           RRESP_S3,
   input  logic [1:0]           RRESP_S4,
   input  logic [1:0]           RRESP_S5,
   input  logic                 RLAST_S0,
   input  logic                 RLAST_S1,
   input  logic                 RLAST_S2,
   input  logic                 RLAST_S3,
   input  logic                 RLAST_S4,
   input  logic                 RLAST_S5,
   input  logic                 RVALID_S0,
   input  logic                 RVALID_S1,
   input  logic                 RVALID_S2,
   input  logic                 RVALID_S3,
   input  logic                 RVALID_S4,
   input  logic                 RVALID_S5,
   output logic                 RREADY_S0,
   output logic                 RREADY_S1,
   output logic                 RREADY_S2,
   output logic                 RREADY_S3,
   output logic                 RREADY_S4,
   output logic                 RREADY_S5,
   output logic [ID_BITS-1:0]   RID_M0,
   output logic [ID_BITS-1:0]   RID_M1,
   output logic [DATA_BITS-1:0] RDATA_M0,
   output logic [DATA_BITS-1:0] RDATA_M1,
   output logic [1:0]           RRESP_M0,
   output logic [1:0]           RRESP_M1,
   output logic                 RLAST_M0,
   output logic                 RLAST_M1,
   output logic                 RVALID_M0,
   output logic                 RVALID_M1,
   input  logic                 RREADY_M0,
   input  logic                 RREADY_M1
);

   localparam int NS       = 6;
   localparam int NM       = 2;
   localparam int TAG_BITS = IDS_BITS - ID_BITS;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

   logic [IDS_BITS-1:0]  rid_s   [NS];
   logic [DATA_BITS-1:0] rdata_s [NS];
   logic [1:0]           rresp_s [NS];
   logic [NS-1:0]        rlast_s, rvalid_s, drop_s, rready_s;
   logic [NS-1:0]        req      [NM];
   logic [NS-1:0]        rready_g [NM];

   state_e               state_q [NM], state_d [NM];
   logic [2:0]           grant_q [NM], grant_d [NM];
   logic [2:0]           ptr_q   [NM], ptr_d   [NM];

   logic [ID_BITS-1:0]   rid_m   [NM];
   logic [DATA_BITS-1:0] rdata_m [NM];
   logic [1:0]           rresp_m [NM];
   logic [NM-1:0]        rlast_m, rvalid_m, rready_m;

   assign rid_s   = '{RID_S0, RID_S1, RID_S2, RID_S3, RID_S4, RID_S5};
   assign rdata_s = '{RDATA_S0, RDATA_S1, RDATA_S2, RDATA_S3, RDATA_S4, RDATA_S5};
   assign rresp_s = '{RRESP_S0, RRESP_S1, RRESP_S2, RRESP_S3, RRESP_S4, RRESP_S5};
   assign rlast_s  = {RLAST_S5, RLAST_S4, RLAST_S3, RLAST_S2, RLAST_S1, RLAST_S0};
   assign rvalid_s = {RVALID_S5, RVALID_S4, RVALID_S3, RVALID_S2, RVALID_S1, RVALID_S0};
   assign rready_m = {RREADY_M1, RREADY_M0};

   // First requester at or after start, wrapping S5 -> S0.
   function automatic logic [2:0] arb_pick(input logic [NS-1:0] req_v, input logic [2:0] start);
      logic [2:0] sel;
      logic [3:0] sum;
      sel = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         sum = {1'b0, start} + 4'(i);
         if (sum >= 4'(NS)) sum = sum - 4'(NS);
         if (req_v[sum[2:0]]) sel = sum[2:0];
      end
      return sel;
   endfunction

   // Tags outside {0,1} are accepted and discarded so a stray beat cannot wedge its slave.
   always_comb begin
      drop_s = '0;
      for (int m = 0; m < NM; m++) req[m] = '0;
      for (int s = 0; s < NS; s++) begin
         for (int m = 0; m < NM; m++)
            req[m][s] = rvalid_s[s] && (rid_s[s][IDS_BITS-1:ID_BITS] == TAG_BITS'(m));
         drop_s[s] = rst && rvalid_s[s] && (rid_s[s][IDS_BITS-1:ID_BITS] > TAG_BITS'(1));
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      logic [2:0] pick;
      for (int m = 0; m < NM; m++) begin
         state_d[m]  = state_q[m];
         grant_d[m]  = grant_q[m];
         ptr_d[m]    = ptr_q[m];
         rid_m[m]    = '0;
         rdata_m[m]  = '0;
         rresp_m[m]  = '0;
         rlast_m[m]  = 1'b0;
         rvalid_m[m] = 1'b0;
         rready_g[m] = '0;
         pick        = arb_pick(req[m], RR_EN ? ptr_q[m] : 3'd0);
         case (state_q[m])
            IDLE: begin
               if (|req[m]) begin
                  state_d[m] = BURST;
                  grant_d[m] = pick;
                  ptr_d[m]   = (pick == 3'(NS - 1)) ? 3'd0 : pick + 3'd1;
               end
            end
            BURST: begin
               rid_m[m]    = rid_s[grant_q[m]][ID_BITS-1:0];
               rdata_m[m]  = rdata_s[grant_q[m]];
               rresp_m[m]  = rresp_s[grant_q[m]];
               rlast_m[m]  = rlast_s[grant_q[m]];
               rvalid_m[m] = rvalid_s[grant_q[m]];
               rready_g[m][grant_q[m]] = rready_m[m];
               if (rvalid_s[grant_q[m]] && rready_m[m] && rlast_s[grant_q[m]])
                  state_d[m] = IDLE;
            end
            default: state_d[m] = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int m = 0; m < NM; m++) begin
            state_q[m] <= IDLE;
            grant_q[m] <= '0;
            ptr_q[m]   <= '0;
         end
      end else begin
         for (int m = 0; m < NM; m++) begin
            state_q[m] <= state_d[m];
            grant_q[m] <= grant_d[m];
            ptr_q[m]   <= ptr_d[m];
         end
      end
   end

   assign rready_s = rready_g[0] | rready_g[1] | drop_s;

   assign {RREADY_S5, RREADY_S4, RREADY_S3, RREADY_S2, RREADY_S1, RREADY_S0} = rready_s;

   assign RID_M0    = rid_m[0];
   assign RID_M1    = rid_m[1];
   assign RDATA_M0  = rdata_m[0];
   assign RDATA_M1  = rdata_m[1];
   assign RRESP_M0  = rresp_m[0];
   assign RRESP_M1  = rresp_m[1];
   assign RLAST_M0  = rlast_m[0];
   assign RLAST_M1  = rlast_m[1];
   assign RVALID_M0 = rvalid_m[0];
   assign RVALID_M1 = rvalid_m[1];

endmodule

// File: tb/tb_read_data_router.sv
// Directed bench for read_data_router: a round-robin instance plus a fixed-priority instance
// that share all slave-side and master-side inputs.
module tb_read_data_router;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rid_s   [6];
   logic [31:0] rdata_s [6];
   logic [1:0]  rresp_s [6];
   logic [5:0]  rlast_s, rvalid_s, rready_s, fp_rready_s;
   logic [1:0]  rready_m;

   logic [3:0]  rid_m   [2], fp_rid_m   [2];
   logic [31:0] rdata_m [2], fp_rdata_m [2];
   logic [1:0]  rresp_m [2], fp_rresp_m [2];
   logic [1:0]  rlast_m, rvalid_m, fp_rlast_m, fp_rvalid_m;

   int n_checks = 0;
   int n_errors = 0;

   logic [5:0] exp_rr [4] = '{6'b000001, 6'b010000, 6'b100000, 6'b000001};
   logic [3:0] exp_id [4] = '{4'h0, 4'h4, 4'h5, 4'h0};

   always #5 clk = ~clk;

   read_data_router #(.ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .RID_S0(rid_s[0]), .RID_S1(rid_s[1]), .RID_S2(rid_s[2]),
      .RID_S3(rid_s[3]), .RID_S4(rid_s[4]), .RID_S5(rid_s[5]),
      .RDATA_S0(rdata_s[0]), .RDATA_S1(rdata_s[1]), .RDATA_S2(rdata_s[2]),
      .RDATA_S3(rdata_s[3]), .RDATA_S4(rdata_s[4]), .RDATA_S5(rdata_s[5]),
      .RRESP_S0(rresp_s[0]), .RRESP_S1(rresp_s[1]), .RRESP_S2(rresp_s[2]),
      .RRESP_S3(rresp_s[3]), .RRESP_S4(rresp_s[4]), .RRESP_S5(rresp_s[5]),
      .RLAST_S0(rlast_s[0]), .RLAST_S1(rlast_s[1]), .RLAST_S2(rlast_s[2]),
      .RLAST_S3(rlast_s[3]), .RLAST_S4(rlast_s[4]), .RLAST_S5(rlast_s[5]),
      .RVALID_S0(rvalid_s[0]), .RVALID_S1(rvalid_s[1]), .RVALID_S2(rvalid_s[2]),
      .RVALID_S3(rvalid_s[3]), .RVALID_S4(rvalid_s[4]), .RVALID_S5(rvalid_s[5]),
      .RREADY_S0(rready_s[0]), .RREADY_S1(rready_s[1]), .RREADY_S2(rready_s[2]),
      .RREADY_S3(rready_s[3]), .RREADY_S4(rready_s[4]), .RREADY_S5(rready_s[5]),
      .RID_M0(rid_m[0]), .RID_M1(rid_m[1]),
      .RDATA_M0(rdata_m[0]), .RDATA_M1(rdata_m[1]),
      .RRESP_M0(rresp_m[0]), .RRESP_M1(rresp_m[1]),
      .RLAST_M0(rlast_m[0]), .RLAST_M1(rlast_m[1]),
      .RVALID_M0(rvalid_m[0]), .RVALID_M1(rvalid_m[1]),
      .RREADY_M0(rready_m[0]), .RREADY_M1(rready_m[1])
   );

   read_data_router #(.ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .RID_S0(rid_s[0]), .RID_S1(rid_s[1]), .RID_S2(rid_s[2]),
      .RID_S3(rid_s[3]), .RID_S4(rid_s[4]), .RID_S5(rid_s[5]),
      .RDATA_S0(rdata_s[0]), .RDATA_S1(rdata_s[1]), .RDATA_S2(rdata_s[2]),
      .RDATA_S3(rdata_s[3]), .RDATA_S4(rdata_s[4]), .RDATA_S5(rdata_s[5]),
      .RRESP_S0(rresp_s[0]), .RRESP_S1(rresp_s[1]), .RRESP_S2(rresp_s[2]),
      .RRESP_S3(rresp_s[3]), .RRESP_S4(rresp_s[4]), .RRESP_S5(rresp_s[5]),
      .RLAST_S0(rlast_s[0]), .RLAST_S1(rlast_s[1]), .RLAST_S2(rlast_s[2]),
      .RLAST_S3(rlast_s[3]), .RLAST_S4(rlast_s[4]), .RLAST_S5(rlast_s[5]),
      .RVALID_S0(rvalid_s[0]), .RVALID_S1(rvalid_s[1]), .RVALID_S2(rvalid_s[2]),
      .RVALID_S3(rvalid_s[3]), .RVALID_S4(rvalid_s[4]), .RVALID_S5(rvalid_s[5]),
      .RREADY_S0(fp_rready_s[0]), .RREADY_S1(fp_rready_s[1]), .RREADY_S2(fp_rready_s[2]),
      .RREADY_S3(fp_rready_s[3]), .RREADY_S4(fp_rready_s[4]), .RREADY_S5(fp_rready_s[5]),
      .RID_M0(fp_rid_m[0]), .RID_M1(fp_rid_m[1]),
      .RDATA_M0(fp_rdata_m[0]), .RDATA_M1(fp_rdata_m[1]),
      .RRESP_M0(fp_rresp_m[0]), .RRESP_M1(fp_rresp_m[1]),
      .RLAST_M0(fp_rlast_m[0]), .RLAST_M1(fp_rlast_m[1]),
      .RVALID_M0(fp_rvalid_m[0]), .RVALID_M1(fp_rvalid_m[1]),
      .RREADY_M0(rready_m[0]), .RREADY_M1(rready_m[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] s, input logic [7:0] id, input logic [31:0] d,
                        input logic l);
      rid_s[s]    = id;
      rdata_s[s]  = d;
      rlast_s[s]  = l;
      rvalid_s[s] = 1'b1;
   endtask

   task automatic idle_s(input logic [2:0] s);
      rvalid_s[s] = 1'b0;
      rlast_s[s]  = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      rlast_s  = '0;
      rvalid_s = '0;
      rready_m = '0;
      for (int s = 0; s < 6; s++) begin
         rid_s[s]   = '0;
         rdata_s[s] = '0;
         rresp_s[s] = '0;
      end

      // Reset state
      #12;
      check("rst_rvalid", 64'(rvalid_m), 0);
      check("rst_rready_s", 64'(rready_s), 0);
      check("rst_fp_rvalid", 64'(fp_rvalid_m), 0);
      @(negedge clk);
      rst = 1'b1;

      // 4-beat burst S2 -> M0
      tick();
      rready_m   = 2'b01;
      rresp_s[2] = 2'b10;
      drive(3'd2, 8'h05, 32'hA000_0000, 1'b0);
      samp();
      check("t1_lat_rvalid", 64'(rvalid_m[0]), 0);
      check("t1_lat_rready", 64'(rready_s[2]), 0);
      for (int b = 0; b < 4; b++) begin
         tick();
         if (b > 0) drive(3'd2, 8'h05, 32'hA000_0000 + 32'(b), b == 3);
         samp();
         check("t1_rvalid", 64'(rvalid_m[0]), 1);
         check("t1_rid", 64'(rid_m[0]), 4'h5);
         check("t1_data", 64'(rdata_m[0]), 32'hA000_0000 + 32'(b));
         check("t1_last", 64'(rlast_m[0]), 64'(b == 3));
         check("t1_rready", 64'(rready_s[2]), 1);
      end
      check("t1_resp", 64'(rresp_m[0]), 2'b10);
      tick();
      idle_s(3'd2);
      samp();
      check("t1_idle", 64'(rvalid_m[0]), 0);

      // Concurrent S1 -> M0 and S3 -> M1
      tick();
      rready_m = 2'b11;
      drive(3'd1, 8'h07, 32'hB0, 1'b0);
      drive(3'd3, 8'h1A, 32'hC0, 1'b0);
      samp();
      check("t2_lat", 64'(rvalid_m), 0);
      tick();
      rready_m[1] = 1'b0;
      samp();
      check("t2_m0_rvalid", 64'(rvalid_m[0]), 1);
      check("t2_m0_rid", 64'(rid_m[0]), 4'h7);
      check("t2_m0_data0", 64'(rdata_m[0]), 32'hB0);
      check("t2_m1_rvalid", 64'(rvalid_m[1]), 1);
      check("t2_m1_rid", 64'(rid_m[1]), 4'hA);
      check("t2_m1_data0", 64'(rdata_m[1]), 32'hC0);
      check("t2_rready_s1", 64'(rready_s[1]), 1);
      check("t2_rready_s3_stall", 64'(rready_s[3]), 0);
      tick();
      rready_m[1] = 1'b1;
      drive(3'd1, 8'h07, 32'hB1, 1'b1);
      samp();
      check("t2_m0_data1", 64'(rdata_m[0]), 32'hB1);
      check("t2_m0_last", 64'(rlast_m[0]), 1);
      check("t2_m1_hold", 64'(rdata_m[1]), 32'hC0);
      check("t2_rready_s3", 64'(rready_s[3]), 1);
      tick();
      idle_s(3'd1);
      drive(3'd3, 8'h1A, 32'hC1, 1'b1);
      samp();
      check("t2_m0_done", 64'(rvalid_m[0]), 0);
      check("t2_m1_data1", 64'(rdata_m[1]), 32'hC1);
      check("t2_m1_last", 64'(rlast_m[1]), 1);
      tick();
      idle_s(3'd3);
      samp();
      check("t2_m1_done", 64'(rvalid_m[1]), 0);

      // Master stall for 3 cycles mid-burst on S4
      tick();
      rready_m = 2'b01;
      drive(3'd4, 8'h02, 32'hE0, 1'b0);
      samp();
      check("t3_lat", 64'(rvalid_m[0]), 0);
      tick();
      samp();
      check("t3_data0", 64'(rdata_m[0]), 32'hE0);
      check("t3_rready0", 64'(rready_s[4]), 1);
      tick();
      drive(3'd4, 8'h02, 32'hE1, 1'b0);
      rready_m[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         samp();
         check("t3_stall_valid", 64'(rvalid_m[0]), 1);
         check("t3_stall_data", 64'(rdata_m[0]), 32'hE1);
         check("t3_stall_rready", 64'(rready_s[4]), 0);
      end
      tick();
      rready_m[0] = 1'b1;
      samp();
      check("t3_data1", 64'(rdata_m[0]), 32'hE1);
      check("t3_rready1", 64'(rready_s[4]), 1);
      tick();
      drive(3'd4, 8'h02, 32'hE2, 1'b1);
      samp();
      check("t3_data2", 64'(rdata_m[0]), 32'hE2);
      check("t3_last", 64'(rlast_m[0]), 1);
      tick();
      idle_s(3'd4);
      samp();
      check("t3_done", 64'(rvalid_m[0]), 0);

      // Illegal tag is dropped
      tick();
      drive(3'd2, 8'h35, 32'hDEAD, 1'b1);
      samp();
      check("t4_drop_rready", 64'(rready_s[2]), 1);
      check("t4_no_fwd", 64'(rvalid_m), 0);
      tick();
      samp();
      check("t4_drop_only", 64'(rready_s), 6'b000100);
      check("t4_no_fwd2", 64'(rvalid_m), 0);
      tick();
      idle_s(3'd2);

      // Reset during beat 2 of 4, then arbitration restarts from S0
      drive(3'd2, 8'h03, 32'h50, 1'b0);
      tick();
      tick();
      drive(3'd2, 8'h03, 32'h51, 1'b0);
      samp();
      check("t6_pre_valid", 64'(rvalid_m[0]), 1);
      #1 rst = 1'b0;
      #1;
      check("t6_async_valid", 64'(rvalid_m), 0);
      check("t6_async_data", 64'(rdata_m[0]), 0);
      check("t6_async_rready", 64'(rready_s), 0);
      tick();
      idle_s(3'd2);
      drive(3'd1, 8'h01, 32'h11, 1'b1);
      drive(3'd4, 8'h04, 32'h44, 1'b1);
      samp();
      check("t6_held_rready", 64'(rready_s), 0);
      rst = 1'b1;
      tick();
      samp();
      check("t6_grant_s1", 64'(rready_s), 6'b000010);
      check("t6_rid_s1", 64'(rid_m[0]), 4'h1);
      check("t6_data_s1", 64'(rdata_m[0]), 32'h11);
      tick();
      idle_s(3'd1);
      samp();
      check("t6_bubble", 64'(rready_s), 0);
      tick();
      samp();
      check("t6_grant_s4", 64'(rready_s), 6'b010000);
      check("t6_rid_s4", 64'(rid_m[0]), 4'h4);
      tick();
      idle_s(3'd4);

      // Round-robin vs fixed priority: S0, S4, S5 continuously request M1
      rready_m = 2'b10;
      drive(3'd0, 8'h10, 32'h100, 1'b1);
      drive(3'd4, 8'h14, 32'h104, 1'b1);
      drive(3'd5, 8'h15, 32'h105, 1'b1);
      samp();
      check("rr_idle", 64'(rready_s), 0);
      check("fp_idle", 64'(fp_rready_s), 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         samp();
         check("rr_grant", 64'(rready_s), 64'(exp_rr[k]));
         check("rr_rid", 64'(rid_m[1]), 64'(exp_id[k]));
         check("fp_grant", 64'(fp_rready_s), 6'b000001);
         check("fp_rid", 64'(fp_rid_m[1]), 4'h0);
         check("fp_data", 64'(fp_rdata_m[1]), 32'h100);
         check("fp_last", 64'(fp_rlast_m[1]), 1);
         check("fp_resp", 64'(fp_rresp_m[1]), 2'b00);
         tick();
         samp();
         check("rr_bubble", 64'(rvalid_m[1]), 0);
         check("fp_bubble", 64'(fp_rvalid_m[1]), 0);
      end
      tick();
      idle_s(3'd0);
      idle_s(3'd4);
      idle_s(3'd5);
      samp();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
